// File: rtl/fpu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_ctrl_pkg
//  Description : Shared FPU definitions (operand, rounding-mode and command
//                widths) plus the issue-controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_issue_ctrl_pkg;

    localparam int C_OP  = 32;  // single-precision operand / result width
    localparam int C_RM  = 3;   // IEEE rounding-mode field
    localparam int C_CMD = 4;   // FPU operator select

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fpu_issue_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_ctrl_if
//  Description : Request, FPU and writeback buses of the issue controller.
//                Signal suffixes are from the controller's point of view;
//                the controller uses the slave modport, its environment the
//                master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    import fpu_issue_ctrl_pkg::*;

    // core -> controller request
    logic             req_valid_i;
    logic             req_ready_o;
    logic [C_OP-1:0]  req_op_a_i;
    logic [C_OP-1:0]  req_op_b_i;
    logic [C_RM-1:0]  req_rm_i;
    logic [C_CMD-1:0] req_cmd_i;
    logic [TAG_W-1:0] req_tag_i;

    // controller <-> FPU wrapper
    logic [C_OP-1:0]  fpu_op_a_o;
    logic [C_OP-1:0]  fpu_op_b_o;
    logic [C_RM-1:0]  fpu_rm_o;
    logic [C_CMD-1:0] fpu_cmd_o;
    logic             fpu_enable_o;
    logic             fpu_stall_o;
    logic [C_OP-1:0]  fpu_result_i;
    logic             fpu_result_valid_i;

    // controller -> writeback
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [C_OP-1:0]  wb_result_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic             wb_err_o;

    modport slave (
        input  req_valid_i, req_op_a_i, req_op_b_i, req_rm_i, req_cmd_i, req_tag_i,
        output req_ready_o,
        output fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o, fpu_enable_o, fpu_stall_o,
        input  fpu_result_i, fpu_result_valid_i,
        output wb_valid_o, wb_result_o, wb_tag_o, wb_err_o,
        input  wb_ready_i
    );

    modport master (
        output req_valid_i, req_op_a_i, req_op_b_i, req_rm_i, req_cmd_i, req_tag_i,
        input  req_ready_o,
        input  fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o, fpu_enable_o, fpu_stall_o,
        output fpu_result_i, fpu_result_valid_i,
        input  wb_valid_o, wb_result_o, wb_tag_o, wb_err_o,
        output wb_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_ctrl
//  Description : Single-outstanding FP issue/writeback controller in front of
//                the FPU wrapper. Holds operands stable, drives FPU
//                enable/stall, captures the result, returns it with its tag
//                to writeback. Supports flush and a latency watchdog.
//  Options     : FPU_ISSUE_PERF_CNT_EN - adds perf_ops_o / perf_busy_o
//                counters (absent when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int MAX_LAT = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        flush_i,
`ifdef FPU_ISSUE_PERF_CNT_EN
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_busy_o,
`endif
    fpu_issue_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] C_WD_LAST = CNT_W'(MAX_LAT - 1);

    fpu_issue_state_t state_q, state_d;

    logic [C_OP-1:0]  op_a_q, op_b_q, result_q;
    logic [C_RM-1:0]  rm_q;
    logic [C_CMD-1:0] cmd_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic req_ready;
    logic req_hs;
    logic wd_expire;
    logic capture;
    logic timeout;
    logic fpu_active;

    assign req_hs     = bus.req_valid_i & req_ready;
    assign wd_expire  = (cnt_q == C_WD_LAST);
    assign fpu_active = (state_q == BUSY) | (state_q == DRAIN);

    // State register; asynchronous reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, request acceptance and capture strobes.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = ~flush_i;
                if (req_hs) state_d = BUSY;
            end
            BUSY: begin
                if (flush_i) begin
                    // An FPU that finishes in the flush cycle needs no drain.
                    state_d = (bus.fpu_result_valid_i | wd_expire) ? IDLE : DRAIN;
                end else if (bus.fpu_result_valid_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (wd_expire) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (bus.fpu_result_valid_i | wd_expire) state_d = IDLE;
            end
            DONE: begin
                req_ready = bus.wb_ready_i & ~flush_i;
                if (flush_i)            state_d = IDLE;
                else if (req_hs)        state_d = BUSY;
                else if (bus.wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding registers, watchdog counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            rm_q     <= '0;
            cmd_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (req_hs) begin
                op_a_q <= bus.req_op_a_i;
                op_b_q <= bus.req_op_b_i;
                rm_q   <= bus.req_rm_i;
                cmd_q  <= bus.req_cmd_i;
                tag_q  <= bus.req_tag_i;
                cnt_q  <= '0;
            end else if (fpu_active) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                result_q <= bus.fpu_result_i;
                err_q    <= 1'b0;
            end else if (timeout) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.fpu_op_a_o   = op_a_q;
    assign bus.fpu_op_b_o   = op_b_q;
    assign bus.fpu_rm_o     = rm_q;
    assign bus.fpu_cmd_o    = cmd_q;
    assign bus.fpu_enable_o = fpu_active;
    assign bus.fpu_stall_o  = ~fpu_active;
    assign bus.wb_valid_o   = (state_q == DONE);
    assign bus.wb_result_o  = result_q;
    assign bus.wb_tag_o     = tag_q;
    assign bus.wb_err_o     = (state_q == DONE) & err_q;

`ifdef FPU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_busy_q;

    // Completed writebacks and FPU-occupied cycles, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (bus.wb_valid_o & bus.wb_ready_i) perf_ops_q  <= perf_ops_q + 32'd1;
            if (fpu_active)                      perf_busy_q <= perf_busy_q + 32'd1;
        end
    end

    assign perf_ops_o  = perf_ops_q;
    assign perf_busy_o = perf_busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_issue_ctrl
//  Description : Self-checking bench for fpu_issue_ctrl with a 2-cycle FPU
//                stand-in and a writeback scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;

    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [3:0]  cmd;
        logic [4:0]  tag;
        logic        mute;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [4:0]  tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    logic fpu_mute;
    logic [31:0] cur_res;
    logic        cur_err;
    logic [1:0]  fpu_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat;
    vec_t        vecs [5];
    sb_t         sb_q [$];

    fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

`ifdef FPU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_ops, perf_busy;
`endif

    fpu_issue_ctrl #(.TAG_W(TAG_W), .MAX_LAT(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
`ifdef FPU_ISSUE_PERF_CNT_EN
        .perf_ops_o  (perf_ops),
        .perf_busy_o (perf_busy),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Stand-in FPU arithmetic: the one real FP add the bench relies on,
    // otherwise simple integer operations that are easy to predict by hand.
    function automatic logic [31:0] fpm(logic [31:0] a, logic [31:0] b, logic [3:0] cmd);
        if (cmd == 4'd0) return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
        if (cmd == 4'd1) return a ^ b;
        return a - b;
    endfunction

    // 2-cycle FPU: result_valid in the second enabled cycle of each window.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    fpu_cnt <= 2'd0;
        else if (bus.fpu_enable_o && !bus.fpu_stall_o) fpu_cnt <= (fpu_cnt == 2'd3) ? 2'd3 : fpu_cnt + 2'd1;
        else                                           fpu_cnt <= 2'd0;
    end
    assign bus.fpu_result_valid_i = bus.fpu_enable_o && (fpu_cnt == 2'd1) && !fpu_mute;
    assign bus.fpu_result_i       = fpm(bus.fpu_op_a_o, bus.fpu_op_b_o, bus.fpu_cmd_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: push on request handshake, pop and compare on writeback.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid_i && bus.req_ready_o)
                sb_q.push_back('{res: cur_res, err: cur_err, tag: bus.req_tag_i});
            if (bus.wb_valid_o && bus.wb_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    check("sb_result", {32'd0, bus.wb_result_o}, {32'd0, sb_q[0].res});
                    check("sb_tag",    {59'd0, bus.wb_tag_o},    {59'd0, sb_q[0].tag});
                    check("sb_err",    {63'd0, bus.wb_err_o},    {63'd0, sb_q[0].err});
                    sb_q.delete(0);
                end
            end
        end
    end

    // Present one request, wait for acceptance, then count cycles until
    // wb_valid_o (1 = first cycle after the handshake edge).
    task automatic issue(input vec_t v, output int l);
        int g;
        bus.req_op_a_i  = v.a;
        bus.req_op_b_i  = v.b;
        bus.req_rm_i    = v.rm;
        bus.req_cmd_i   = v.cmd;
        bus.req_tag_i   = v.tag;
        bus.req_valid_i = 1'b1;
        cur_res  = v.res;
        cur_err  = v.err;
        fpu_mute = v.mute;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus.req_ready_o) begin
            check("req_accept_timeout", 64'd0, 64'd1);
            bus.req_valid_i = 1'b0;
            l = 0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.req_op_a_i  = ~v.a;   // holding registers must not follow the bus
        #1;
        check("fpu_op_a", {32'd0, bus.fpu_op_a_o}, {32'd0, v.a});
        check("fpu_op_b", {32'd0, bus.fpu_op_b_o}, {32'd0, v.b});
        check("fpu_rm",   {61'd0, bus.fpu_rm_o},   {61'd0, v.rm});
        check("fpu_cmd",  {60'd0, bus.fpu_cmd_o},  {60'd0, v.cmd});
        l = 1;
        while (!bus.wb_valid_o && l < 20) begin
            @(posedge clk); #2;
            l++;
        end
    endtask

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] cmd, logic [4:0] tag,
                                logic [31:0] res);
        return '{a: a, b: b, rm: 3'd0, cmd: cmd, tag: tag, mute: 1'b0, res: res, err: 1'b0, lat: 3};
    endfunction

    initial begin
        vecs[0] = '{a: 32'h3F80_0000, b: 32'h4000_0000, rm: 3'd0, cmd: 4'd0, tag: 5'd7,
                    mute: 1'b0, res: 32'h4040_0000, err: 1'b0, lat: 3};
        vecs[1] = '{a: 32'h1234_5678, b: 32'h0000_FFFF, rm: 3'd1, cmd: 4'd1, tag: 5'd31,
                    mute: 1'b0, res: 32'h1234_A987, err: 1'b0, lat: 3};
        vecs[2] = '{a: 32'h0000_0010, b: 32'h0000_0003, rm: 3'd2, cmd: 4'd2, tag: 5'd0,
                    mute: 1'b0, res: 32'h0000_000D, err: 1'b0, lat: 3};
        vecs[3] = '{a: 32'hDEAD_BEEF, b: 32'h0000_0001, rm: 3'd4, cmd: 4'd0, tag: 5'd16,
                    mute: 1'b1, res: 32'h0000_0000, err: 1'b1, lat: 9};
        vecs[4] = '{a: 32'h0000_0001, b: 32'h0000_0002, rm: 3'd3, cmd: 4'd0, tag: 5'd1,
                    mute: 1'b0, res: 32'h0000_0003, err: 1'b0, lat: 3};

        rst_n = 1'b0;
        flush_i = 1'b0;
        fpu_mute = 1'b0;
        cur_res = '0;
        cur_err = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_a_i  = '0;
        bus.req_op_b_i  = '0;
        bus.req_rm_i    = '0;
        bus.req_cmd_i   = '0;
        bus.req_tag_i   = '0;
        bus.wb_ready_i  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", {63'd0, bus.req_ready_o},  64'd1);
        check("rst_enable",    {63'd0, bus.fpu_enable_o}, 64'd0);
        check("rst_stall",     {63'd0, bus.fpu_stall_o},  64'd1);
        check("rst_wb_valid",  {63'd0, bus.wb_valid_o},   64'd0);
        check("rst_wb_err",    {63'd0, bus.wb_err_o},     64'd0);
        check("rst_wb_result", {32'd0, bus.wb_result_o},  64'd0);
        check("rst_fpu_op_a",  {32'd0, bus.fpu_op_a_o},   64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;

        // Table: single operations, including a watchdog timeout
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i], lat);
            check($sformatf("lat_%0d", i),    lat,                          vecs[i].lat);
            check($sformatf("res_%0d", i),    {32'd0, bus.wb_result_o},     {32'd0, vecs[i].res});
            check($sformatf("tag_%0d", i),    {59'd0, bus.wb_tag_o},        {59'd0, vecs[i].tag});
            check($sformatf("err_%0d", i),    {63'd0, bus.wb_err_o},        {63'd0, vecs[i].err});
            check($sformatf("stall_%0d", i),  {63'd0, bus.fpu_stall_o},     64'd1);
            @(posedge clk); #2;
            check($sformatf("wb_drop_%0d", i), {63'd0, bus.wb_valid_o},     64'd0);
        end
        fpu_mute = 1'b0;

        // Writeback back-pressure: output held stable, no new request accepted
        bus.wb_ready_i = 1'b0;
        issue(mk(32'hA5A5_A5A5, 32'h0F0F_0F0F, 4'd1, 5'd5, 32'hAAAA_AAAA), lat);
        check("hold_lat", lat, 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check("hold_valid",  {63'd0, bus.wb_valid_o},  64'd1);
            check("hold_result", {32'd0, bus.wb_result_o}, 64'hAAAA_AAAA);
            check("hold_tag",    {59'd0, bus.wb_tag_o},    64'd5);
            check("hold_ready",  {63'd0, bus.req_ready_o}, 64'd0);
        end
        bus.wb_ready_i = 1'b1;
        #1;
        check("release_ready", {63'd0, bus.req_ready_o}, 64'd1);
        @(posedge clk); #2;
        check("release_idle", {63'd0, bus.wb_valid_o}, 64'd0);

        // Back-to-back issue from DONE
        issue(mk(32'd1, 32'd1, 4'd0, 5'd2, 32'd2), lat);
        check("b2b_first_lat", lat, 3);
        bus.req_op_a_i  = 32'h0000_0100;
        bus.req_op_b_i  = 32'h0000_0001;
        bus.req_cmd_i   = 4'd2;
        bus.req_tag_i   = 5'd3;
        bus.req_valid_i = 1'b1;
        cur_res = 32'h0000_00FF;
        cur_err = 1'b0;
        #1;
        check("b2b_gap",   {63'd0, bus.fpu_enable_o}, 64'd0);
        check("b2b_ready", {63'd0, bus.req_ready_o},  64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        #1;
        check("b2b_enable", {63'd0, bus.fpu_enable_o}, 64'd1);
        check("b2b_wb1",    {63'd0, bus.wb_valid_o},   64'd0);
        @(posedge clk); #2;
        check("b2b_wb2",    {63'd0, bus.wb_valid_o},   64'd0);
        @(posedge clk); #2;
        check("b2b_wb3",    {63'd0, bus.wb_valid_o},   64'd1);
        check("b2b_tag",    {59'd0, bus.wb_tag_o},     64'd3);
        check("b2b_result", {32'd0, bus.wb_result_o},  64'h0000_00FF);
        @(posedge clk); #2;

        // Flush in the first BUSY cycle: drain, no writeback
        bus.req_op_a_i  = 32'd7;
        bus.req_op_b_i  = 32'd7;
        bus.req_cmd_i   = 4'd1;
        bus.req_tag_i   = 5'd4;
        bus.req_valid_i = 1'b1;
        cur_res = 32'd0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("flush_ready", {63'd0, bus.req_ready_o},  64'd0);
        check("flush_en",    {63'd0, bus.fpu_enable_o}, 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1;
        check("drain_en",    {63'd0, bus.fpu_enable_o}, 64'd1);
        check("drain_wb",    {63'd0, bus.wb_valid_o},   64'd0);
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        @(posedge clk); #2;
        check("drain_exit",  {63'd0, bus.fpu_enable_o}, 64'd0);
        check("drain_no_wb", {63'd0, bus.wb_valid_o},   64'd0);
        // flush beats a simultaneous request
        bus.req_valid_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("flush_beats_req", {63'd0, bus.req_ready_o}, 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        #1;
        check("flush_no_accept", {63'd0, bus.fpu_enable_o}, 64'd0);
        issue(mk(32'h3F80_0000, 32'h4000_0000, 4'd0, 5'd9, 32'h4040_0000), lat);
        check("post_flush_lat", lat, 3);
        check("post_flush_tag", {59'd0, bus.wb_tag_o}, 64'd9);
        @(posedge clk); #2;

        // Asynchronous reset while BUSY
        bus.req_op_a_i  = 32'd1;
        bus.req_op_b_i  = 32'd2;
        bus.req_cmd_i   = 4'd0;
        bus.req_tag_i   = 5'd6;
        bus.req_valid_i = 1'b1;
        cur_res = 32'd3;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        #1;
        check("rst_pre_enable", {63'd0, bus.fpu_enable_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_enable",    {63'd0, bus.fpu_enable_o}, 64'd0);
        check("arst_stall",     {63'd0, bus.fpu_stall_o},  64'd1);
        check("arst_wb_valid",  {63'd0, bus.wb_valid_o},   64'd0);
        check("arst_req_ready", {63'd0, bus.req_ready_o},  64'd1);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("post_rst_wb", {63'd0, bus.wb_valid_o}, 64'd0);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue/writeback controller that sits directly upstream of the private FPU wrapper.
- Accepts one FP request at a time from the core over a valid/ready handshake and holds its operands stable.
- Drives the FPU enable/stall pins and captures the result on the FPU's result-valid pulse.
- Returns the result with its destination tag to writeback over a second valid/ready handshake; supports flush and a latency watchdog.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside the request.
- MAX_LAT, 8, BUSY cycles allowed before the watchdog declares a timeout (must be ≥ 3).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  abort current request (result discarded)
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_op_a_i / req_op_b_i  in  C_OP  operands
- req_rm_i  in  C_RM  rounding mode
- req_cmd_i  in  C_CMD  operator
- req_tag_i  in  TAG_W  destination tag
- fpu_op_a_o / fpu_op_b_o  out  C_OP  operands to FPU
- fpu_rm_o  out  C_RM; fpu_cmd_o  out  C_CMD
- fpu_enable_o  out  1  FPU enable
- fpu_stall_o  out  1  FPU stall
- fpu_result_i  in  C_OP  FPU result
- fpu_result_valid_i  in  1  FPU result valid
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  writeback ready
- wb_result_o  out  C_OP  result
- wb_tag_o  out  TAG_W  tag
- wb_err_o  out  1  result produced by watchdog timeout (wb_result_o = 0)

Behaviour:
- States: IDLE, BUSY, DRAIN, DONE. Reset → IDLE; all holding, result and tag registers → 0; wb_valid_o=0, wb_err_o=0, req_ready_o=1, fpu_enable_o=0, fpu_stall_o=1.
- req_ready_o = (IDLE) | (DONE & wb_ready_i) — back-to-back issue allowed; forced 0 while flush_i=1.
- On req handshake: latch operands, rm, cmd, tag into holding regs; clear watchdog counter; next state BUSY.
- fpu_op_*/rm/cmd always driven from holding regs (stable for whole operation).
- fpu_enable_o = BUSY | DRAIN. fpu_stall_o = IDLE | DONE (freezes FPU input regs when idle).
- BUSY: counter += 1 per cycle. fpu_result_valid_i=1 → capture fpu_result_i into result reg, wb_err=0, → DONE. Counter reaches MAX_LAT-1 without valid → result=0, wb_err=1, → DONE.
- Latency with 2-cycle FPU: handshake cycle N, result_valid sampled N+2, wb_valid_o high from N+3.
- DONE: wb_valid_o=1, wb_result_o/wb_tag_o/wb_err_o held stable until wb_ready_i. On wb_ready_i: → BUSY if new req handshake in same cycle, else IDLE.
- flush_i: IDLE/DONE → IDLE, wb_valid_o drops next cycle, result lost. BUSY → DRAIN (FPU must finish its count). DRAIN: enable held; on fpu_result_valid_i or watchdog expiry → IDLE, result discarded. flush_i in DRAIN has no further effect. Flush beats a simultaneous req handshake (request not accepted).
- Simultaneous fpu_result_valid_i and watchdog expiry: valid wins (wb_err=0).
- fpu_result_valid_i outside BUSY/DRAIN: ignored.
- Reset mid-operation: immediate return to reset values; in-flight result lost.

Optional Feature:
- FPU_ISSUE_PERF_CNT_EN: adds outputs perf_ops_o (32) and perf_busy_o (32).
- perf_ops_o increments on each wb handshake; perf_busy_o increments each BUSY/DRAIN cycle.
- Both reset to 0 and wrap modulo 2^32.
- Without the macro, ports and counters are absent.

Decomposition:
- Add typedef enum fpu_issue_state_t {IDLE, BUSY, DRAIN, DONE} to fpu_defs; reuse its C_OP/C_RM/C_CMD.
- No sub-module: watchdog counter ($clog2(MAX_LAT) bits) and FSM kept inline.

Test Plan:
- Single add, 0x3F800000 + 0x40000000, tag 7, wb_ready_i=1 → wb_valid_o at handshake+3, wb_result_o=0x40400000, wb_tag_o=7, wb_err_o=0.
- wb_ready_i held 0 for 5 cycles after result → wb_valid_o, result and tag stable; req_ready_o=0; release → IDLE next cycle.
- Back-to-back: second request (tag 3) presented while DONE & wb_ready_i → accepted same cycle; second wb_valid_o exactly 3 cycles later; fpu_enable_o has one-cycle gap.
- flush_i pulsed in first BUSY cycle → DRAIN, enable stays high until result_valid; no wb_valid_o; next request completes correctly with tag 9.
- FPU model never asserts result_valid, MAX_LAT=8 → wb_valid_o after 8 BUSY cycles with wb_err_o=1, wb_result_o=0.
- rst_n asserted asynchronously in BUSY → fpu_enable_o=0, fpu_stall_o=1, wb_valid_o=0, req_ready_o=1 immediately.
